// File: rtl/ak4619_tdm.sv
// TDM128 master for one AK4619 codec: derives bick/lrck from the 12 MHz MCLK and moves
// four DAC and four ADC slots per frame as parallel signed words.

// One codec slot: transmit word latched per frame, receive word assembled bit by bit.
module ak4619_slot #(
  parameter int W = 16
) (
  input  logic         clk_12mhz,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] dac,
  input  logic [4:0]   tx_pos,
  output logic         tx_bit,
  input  logic         cap,
  input  logic [4:0]   rx_pos,
  input  logic         sdout1,
  input  logic         publish,
  output logic [W-1:0] adc
);
  localparam int PAD = 32 - W;

  logic [W-1:0] tx_q, tx_src, rx_q;

  // At a frame boundary the first bit must come straight from the incoming sample.
  assign tx_src = load ? dac : tx_q;

  // Word is MSB-justified in 32 bits; positions below PAD carry zeros.
  always_comb begin
    tx_bit = 1'b0;
    for (int i = 0; i < W; i++)
      if (tx_pos == 5'(i + PAD)) tx_bit = tx_src[i];
  end

  always_ff @(posedge clk_12mhz or negedge rst_n) begin
    if (!rst_n) begin
      tx_q <= '0;
      rx_q <= '0;
      adc  <= '0;
    end else begin
      if (load) tx_q <= dac;
      for (int i = 0; i < W; i++)
        if (cap && rx_pos == 5'(i + PAD)) rx_q[i] <= sdout1;
      if (publish) adc <= rx_q;
    end
  end
endmodule

module ak4619_tdm #(
  parameter int W = 16
) (
  input  logic         clk_12mhz,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] dac0,
  input  logic [W-1:0] dac1,
  input  logic [W-1:0] dac2,
  input  logic [W-1:0] dac3,
  output logic [W-1:0] adc0,
  output logic [W-1:0] adc1,
  output logic [W-1:0] adc2,
  output logic [W-1:0] adc3,
  output logic         sample_strobe,
  output logic         bick,
  output logic         lrck,
  output logic         sdin1,
  input  logic         sdout1
);
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic       active, active_nx, wrap, boundary, cap;
  logic       bick_nx, lrck_nx, sdin_nx;
  logic [4:0] tx_pos, rx_pos;

  logic [NUM_LANES-1:0][W-1:0] dac_v, adc_v;
  logic [NUM_LANES-1:0]        tx_bits, cap_v;

  assign dac_v  = {dac3, dac2, dac1, dac0};
  assign active = (state != IDLE);
  assign wrap   = active && (cnt == 8'hFF);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (en) state_nx = RUN;
      RUN:     if (!en) state_nx = wrap ? IDLE : DRAIN;
      DRAIN:   if (wrap) state_nx = en ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are registered from next-cycle values so every pin is a flop.
  always_comb begin
    active_nx = (state_nx != IDLE);
    cnt_nx    = (active && active_nx) ? cnt + 8'd1 : 8'd0;
    boundary  = (!active && active_nx) || wrap;
    tx_pos    = ~cnt_nx[5:1];
    bick_nx   = active_nx & cnt_nx[0];
    lrck_nx   = active_nx & ~cnt_nx[7];
    sdin_nx   = active_nx & tx_bits[cnt_nx[7:6]];
  end

  // Sample sdout1 at the end of each even cycle, i.e. on the bick rising edge.
  assign cap    = active && !cnt[0];
  assign rx_pos = ~cnt[5:1];

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign cap_v[i] = cap && (cnt[7:6] == 2'(i));
    ak4619_slot #(.W(W)) u_slot (
      .clk_12mhz (clk_12mhz),
      .rst_n     (rst_n),
      .load      (boundary),
      .dac       (dac_v[i]),
      .tx_pos    (tx_pos),
      .tx_bit    (tx_bits[i]),
      .cap       (cap_v[i]),
      .rx_pos    (rx_pos),
      .sdout1    (sdout1),
      .publish   (wrap),
      .adc       (adc_v[i])
    );
  end

  assign adc0 = adc_v[0];
  assign adc1 = adc_v[1];
  assign adc2 = adc_v[2];
  assign adc3 = adc_v[3];

  always_ff @(posedge clk_12mhz or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      bick          <= 1'b0;
      lrck          <= 1'b0;
      sdin1         <= 1'b0;
      sample_strobe <= 1'b0;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      bick          <= bick_nx;
      lrck          <= lrck_nx;
      sdin1         <= sdin_nx;
      sample_strobe <= wrap;
    end
  end
endmodule

// File: tb/tb_ak4619_tdm.sv
// Bench for ak4619_tdm: frame vectors with a codec model, scoreboard of per-frame expectations.
module tb_ak4619_tdm;
  localparam int W  = 16;
  localparam int NV = 10;

  logic clk_12mhz = 1'b0;
  logic rst_n = 1'b0, en = 1'b0;
  logic [W-1:0] dac0 = '0, dac1 = '0, dac2 = '0, dac3 = '0;
  logic [W-1:0] adc0, adc1, adc2, adc3;
  logic sample_strobe, bick, lrck, sdin1;
  logic sdout1 = 1'b0;

  always #5 clk_12mhz = ~clk_12mhz;

  ak4619_tdm #(.W(W)) dut (
    .clk_12mhz(clk_12mhz), .rst_n(rst_n), .en(en),
    .dac0(dac0), .dac1(dac1), .dac2(dac2), .dac3(dac3),
    .adc0(adc0), .adc1(adc1), .adc2(adc2), .adc3(adc3),
    .sample_strobe(sample_strobe), .bick(bick), .lrck(lrck),
    .sdin1(sdin1), .sdout1(sdout1)
  );

  // mode 0: codec sends rxw; 1: sdout1 follows sdin1; 2: sdout1 is sdin1 one clk late
  typedef struct {
    logic [3:0][15:0] dac;
    int               mode;
    logic [3:0][31:0] rxw;
    logic [3:0][15:0] adc;
  } vec_t;
  typedef struct {
    logic [3:0][15:0] adc;
    logic [127:0]     tx;
  } exp_t;

  vec_t vec[NV];
  exp_t sb[$];
  int checks = 0, fails = 0;

  int mode = 0;
  logic [3:0][31:0] rxw = '0;
  logic [7:0] pos = '0;
  logic lrck_q = 1'b0, sd_prev = 1'b0;
  logic [127:0] tx_cap = '0, tx_last = '0;
  int wave_err = 0, wave_last = 0, lr_hi = 0, lr_last = 0;

  // Codec model: frame position from lrck rising, checks clocks, records sdin1, drives sdout1.
  always @(negedge clk_12mhz) begin
    if (lrck && !lrck_q) pos = '0; else pos = pos + 8'd1;
    lrck_q = lrck;
    if (pos == 8'd0) begin wave_err = 0; lr_hi = 0; end
    if (bick !== pos[0] || lrck !== ~pos[7]) wave_err++;
    if (pos[0] && sdin1 !== sd_prev) wave_err++;
    if (lrck) lr_hi++;
    if (!pos[0]) tx_cap[127 - pos[7:1]] = sdin1;
    case (mode)
      1:       sdout1 = sdin1;
      2:       sdout1 = sd_prev;
      default: sdout1 = rxw[pos[7:6]][31 - pos[5:1]];
    endcase
    sd_prev = sdin1;
    if (pos == 8'd255) begin tx_last = tx_cap; wave_last = wave_err; lr_last = lr_hi; end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic add(input int i, input logic [63:0] d, input int m,
                     input logic [127:0] r, input logic [63:0] a);
    vec[i].dac = d; vec[i].mode = m; vec[i].rxw = r; vec[i].adc = a;
  endtask

  function automatic logic [127:0] tx_of(input logic [3:0][15:0] d);
    return {d[0], 16'h0, d[1], 16'h0, d[2], 16'h0, d[3], 16'h0};
  endfunction

  task automatic push_exp(input logic [3:0][15:0] a, input logic [3:0][15:0] d);
    exp_t e;
    e.adc = a; e.tx = tx_of(d);
    sb.push_back(e);
  endtask

  task automatic drive_dac(input logic [3:0][15:0] d);
    dac0 = d[0]; dac1 = d[1]; dac2 = d[2]; dac3 = d[3];
  endtask

  task automatic wait_strobe(input int limit, output int n);
    n = 0;
    do begin @(posedge clk_12mhz); #1; n++; end while (!sample_strobe && n < limit);
    if (!sample_strobe) begin
      checks++; fails++;
      $display("FAIL strobe_timeout: none within %0d cycles", limit);
    end
  endtask

  task automatic check_frame(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++; fails++;
      $display("FAIL %s_sb: no expectation queued", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_adc"}, {adc3, adc2, adc1, adc0}, e.adc);
    chk({tag, "_sdin"}, tx_last, e.tx);
    chk({tag, "_wave"}, wave_last, 0);
    chk({tag, "_lrck_hi"}, lr_last, 128);
  endtask

  int n, skip, err;

  initial begin
    // fields packed high slot first: {s3, s2, s1, s0}
    add(0, {16'h0000, 16'h0000, 16'h0000, 16'h8001}, 0,
        {32'h0, 32'hA5A5_0F0F, 32'h0, 32'h0}, {16'h0000, 16'hA5A5, 16'h0000, 16'h0000});
    add(1, {16'h7FFF, 16'h8000, 16'hFFFF, 16'h1234}, 1, '0,
        {16'h7FFF, 16'h8000, 16'hFFFF, 16'h1234});
    add(2, {16'h7FFF, 16'h8000, 16'hFFFF, 16'h1234}, 1, '0,
        {16'h7FFF, 16'h8000, 16'hFFFF, 16'h1234});
    // one-clk-late loopback: captured stream is the transmit stream one bit later
    add(3, {16'h7FFF, 16'h8000, 16'hFFFF, 16'h1234}, 2, '0,
        {16'h3FFF, 16'h4000, 16'h7FFF, 16'h091A});
    add(4, '0, 0, {32'h7FFF_FFFF, 32'h0001_8000, 32'h8000_0001, 32'hFFFF_FFFF},
        {16'h7FFF, 16'h0001, 16'h8000, 16'hFFFF});
    add(5, {16'hF0F0, 16'h0F0F, 16'h5555, 16'hAAAA}, 1, '0,
        {16'hF0F0, 16'h0F0F, 16'h5555, 16'hAAAA});
    add(6, {16'hF00D, 16'hCAFE, 16'hBEEF, 16'hDEAD}, 2, '0,
        {16'h7806, 16'h657F, 16'h5F77, 16'h6F56});
    add(7, {16'h0001, 16'h0002, 16'h0004, 16'h0008}, 0,
        {32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F, 32'hFFFF_0000},
        {16'h1234, 16'h9ABC, 16'h0F0F, 16'hFFFF});
    add(8, {16'h8000, 16'h8000, 16'h8000, 16'h8000}, 1, '0,
        {16'h8000, 16'h8000, 16'h8000, 16'h8000});
    add(9, {16'h0000, 16'h0000, 16'h0000, 16'h0001}, 0,
        {32'h0000_FFFF, 32'hFFFF_0000, 32'h0001_0000, 32'h8000_FFFF},
        {16'h0000, 16'hFFFF, 16'h0001, 16'h8000});

    repeat (3) begin @(posedge clk_12mhz); #1; end
    chk("rst_bick", bick, 0);
    chk("rst_lrck", lrck, 0);
    chk("rst_sdin1", sdin1, 0);
    chk("rst_strobe", sample_strobe, 0);
    chk("rst_adc", {adc3, adc2, adc1, adc0}, 0);
    @(negedge clk_12mhz); rst_n = 1'b1;
    repeat (3) begin @(posedge clk_12mhz); #1; end
    chk("idle_pins", {bick, lrck, sdin1, sample_strobe}, 0);

    drive_dac(vec[0].dac); mode = vec[0].mode; rxw = vec[0].rxw;
    push_exp(vec[0].adc, vec[0].dac);
    @(negedge clk_12mhz); en = 1'b1;
    @(posedge clk_12mhz); #1;
    chk("start_c0", {lrck, bick}, 2'b10);
    drive_dac(vec[1].dac);

    for (int k = 0; k < NV; k++) begin
      skip = 0;
      if (k == 4) begin
        // en glitch mid-frame must not cut the frame short
        repeat (50) begin @(posedge clk_12mhz); #1; end
        en = 1'b0;
        repeat (10) begin @(posedge clk_12mhz); #1; end
        en = 1'b1;
        skip = 60;
      end
      wait_strobe(300, n);
      chk($sformatf("f%0d_spacing", k), n + skip, 256);
      check_frame($sformatf("f%0d", k));
      if (k + 1 < NV) begin
        mode = vec[k + 1].mode; rxw = vec[k + 1].rxw;
        push_exp(vec[k + 1].adc, vec[k + 1].dac);
        drive_dac((k + 2 < NV) ? vec[k + 2].dac : '0);
      end
    end

    // Drain: drop en at c=100, the frame still completes
    mode = 0;
    rxw = {32'h4444_0000, 32'h3333_0000, 32'h2222_0000, 32'h1111_0000};
    push_exp({16'h4444, 16'h3333, 16'h2222, 16'h1111}, '0);
    repeat (100) begin @(posedge clk_12mhz); #1; end
    en = 1'b0;
    wait_strobe(300, n);
    chk("drain_spacing", n, 156);
    check_frame("drain");
    err = 0;
    repeat (30) begin
      @(posedge clk_12mhz); #1;
      if (bick || lrck || sdin1 || sample_strobe) err++;
    end
    chk("drain_idle_quiet", err, 0);
    chk("drain_adc_hold", {adc3, adc2, adc1, adc0}, 64'h4444_3333_2222_1111);

    drive_dac(vec[0].dac); mode = vec[0].mode; rxw = vec[0].rxw;
    @(negedge clk_12mhz); en = 1'b1;
    @(posedge clk_12mhz); #1;
    chk("rerun_c0", {lrck, bick}, 2'b10);

    // Async reset mid-frame at c=180
    repeat (180) begin @(posedge clk_12mhz); #1; end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pins", {bick, lrck, sdin1, sample_strobe}, 0);
    chk("arst_adc", {adc3, adc2, adc1, adc0}, 0);
    err = 0;
    repeat (5) begin @(posedge clk_12mhz); #1; if (sample_strobe) err++; end
    chk("arst_no_strobe", err, 0);
    push_exp(vec[0].adc, vec[0].dac);
    @(negedge clk_12mhz); rst_n = 1'b1;
    @(posedge clk_12mhz); #1;
    chk("restart_c0", {lrck, bick}, 2'b10);
    wait_strobe(300, n);
    chk("restart_spacing", n, 256);
    check_frame("restart");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
